// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer: streams a run of consecutive words out of the 16x4
// lookup ROM onto a valid/ready output. A credit check over the 2-entry
// output buffer plus the one-cycle ROM read latency keeps backpressure from
// ever dropping a word.
// Optional feature: define ROM_SEQ_ABORT_EN to add the 'abort' input, which
// cancels a run in RUN/DRAIN, flushes the buffer and suppresses done.
module rom_read_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ROM_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] rom_raddr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_issued;
  logic              r_busy;
  logic              r_done;
  // A read was issued last cycle, so rom_dout carries its word this cycle.
  logic              r_vld_p1;
  // Output buffer: two entries, circular pointers, explicit occupancy.
  logic [DATA_W-1:0] r_mem_p2 [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;

  logic              w_abort;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_wr;
  logic              w_pop;
  logic [CNT_W-1:0]  w_issued_nxt;

`ifdef ROM_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Every issued word must have a buffer slot even if out_ready stays low,
  // so words already buffered and the one in flight both consume credit.
  assign w_credit_ok  = ({1'b0, r_occ} + {2'b00, r_vld_p1}) < 3'd2;
  assign w_issue      = (r_state == S_RUN) && (r_issued < r_count) && w_credit_ok;
  assign w_issued_nxt = r_issued + CNT_W'(1);
  assign w_wr         = r_vld_p1 && !w_abort;
  assign w_pop        = out_valid && out_ready;

  assign rom_rd_en = w_issue;
  assign rom_raddr = r_addr;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = out_valid ? r_mem_p2[r_rptr] : '0;
  assign busy      = r_busy;
  assign done      = r_done;

  // Control FSM: run bookkeeping, address stepping, busy/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_count  <= '0;
      r_issued <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_addr   <= base_addr;
              r_count  <= count;
              r_issued <= '0;
              if (count == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_issue) begin
              r_addr   <= r_addr + ADDR_W'(1);
              r_issued <= w_issued_nxt;
              if (w_issued_nxt == r_count) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (!r_vld_p1 && (r_occ == 2'd0)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stage p0 -> p1: remember that a read went out this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= w_issue && !w_abort;
  end

  // Stage p1 -> p2: buffer pointers and occupancy; abort empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else if (w_abort) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_wr)  r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_wr && !w_pop)      r_occ <= r_occ + 2'd1;
      else if (!w_wr && w_pop) r_occ <= r_occ - 2'd1;
    end
  end

  // Stage p1 -> p2: capture the ROM word into the slot the write pointer names.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem_p2[r_wptr] <= rom_dout;
  end

`ifndef SYNTHESIS
  // The credit check must make a write into a full buffer impossible.
  always_comb begin
    assert (!(w_wr && !w_pop && (r_occ == 2'd2)));
    assert (r_occ != 2'd3);
  end
`endif

endmodule

// File: tb/tb_rom_read_sequencer.sv
// tb_rom_read_sequencer: scoreboard bench for rom_read_sequencer with a
// 16x4 ROM model (word[i]=i, word[15]=0). Expected addresses and words are
// queued when a run is started and popped as the DUT issues and delivers.
`timescale 1ns/1ps
module tb_rom_read_sequencer;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  count = '0;
  logic [ADDR_W-1:0] rom_raddr;
  logic              rom_rd_en;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;
`ifdef ROM_SEQ_ABORT_EN
  logic              abort = 1'b0;
`endif

  always #5 clk = ~clk;

  rom_read_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ROM_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rom_raddr (rom_raddr),
    .rom_rd_en (rom_rd_en),
    .rom_dout  (rom_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return (a == 4'hF) ? '0 : DATA_W'(a);
  endfunction

  // ROM model: registers the addressed word when read-enabled, else holds.
  logic [DATA_W-1:0] rom_q = '0;
  always @(posedge clk) if (rom_rd_en) rom_q <= rom_word(rom_raddr);
  assign rom_dout = rom_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int cyc = 0;
  // Cycle counter for latency and ordering measurements.
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  int m_occ = 0, m_infl = 0;
  bit m_rd_prev = 0, m_pop_prev = 0, m_flush = 0;
  int n_done = 0, n_rd = 0, n_pop = 0;
  int t_rd0 = -1, t_vld0 = -1, t_last_pop = -1, t_done = -1;

  // Monitor: occupancy/credit model, address and data scoreboard, done tally.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_occ = 0; m_infl = 0; m_rd_prev = 0; m_pop_prev = 0; m_flush = 0;
    end else begin
      if (m_flush) begin
        m_occ = 0; m_infl = 0; m_flush = 0;
      end else begin
        m_occ  = m_occ + m_infl - int'(m_pop_prev);
        m_infl = int'(m_rd_prev);
      end
      chk("out_valid", 32'(out_valid), 32'(m_occ != 0));
      if (rom_rd_en) begin
        n_rd++;
        if (t_rd0 < 0) t_rd0 = cyc;
        chk("credit", 32'((m_occ + m_infl) < 2), 32'd1);
        if (q_addr.size() > 0) chk("raddr", 32'(rom_raddr), 32'(q_addr.pop_front()));
        else                   chk("extra_rd", 32'd1, 32'd0);
      end
      if (out_valid && t_vld0 < 0) t_vld0 = cyc;
      if (out_valid && out_ready) begin
        n_pop++;
        t_last_pop = cyc;
        if (q_data.size() > 0) chk("data", 32'(out_data), 32'(q_data.pop_front()));
        else                   chk("extra_out", 32'd1, 32'd0);
      end
      if (done) begin
        n_done++;
        t_done = cyc;
      end
      m_rd_prev  = rom_rd_en;
      m_pop_prev = out_valid && out_ready;
`ifdef ROM_SEQ_ABORT_EN
      if (abort && busy) m_flush = 1;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int b, input int c);
    for (int i = 0; i < c; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(b + i);
      q_addr.push_back(a);
      q_data.push_back(rom_word(a));
    end
  endtask

  task automatic issue_start(input int b, input int c);
    base_addr = ADDR_W'(b);
    count     = CNT_W'(c);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit tog);
    int n0 = n_done;
    int k  = 0;
    while (n_done == n0 && k < limit) begin
      tick();
      k++;
      if (tog) out_ready = ~out_ready;
    end
    if (n_done == n0) chk("timeout_done", 32'd1, 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("done_pulses", 32'(n_done - n0), 32'd1);
    chk("q_empty", 32'(q_data.size() + q_addr.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_raddr"}, 32'(rom_raddr), 32'd0);
    chk({tag, "_rd_en"}, 32'(rom_rd_en), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
  endtask

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    int n0, p0, r0, k;
    rst_n = 1'b0;
    repeat (2) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic run with latency and done ordering.
    t_rd0 = -1; t_vld0 = -1;
    push_run(2, 4);
    issue_start(2, 4);
    wait_done(100, 1'b0);
    chk("first_vld_lat", 32'(t_vld0 - t_rd0), 32'd2);
    chk("done_after_last", 32'(t_done > t_last_pop), 32'd1);

    // Address wrap 15 -> 0.
    push_run(14, 4);
    issue_start(14, 4);
    wait_done(100, 1'b0);

    // Full-ROM run under toggling backpressure.
    p0 = n_pop;
    push_run(0, 16);
    issue_start(0, 16);
    wait_done(400, 1'b1);
    chk("full_words", 32'(n_pop - p0), 32'd16);

    // Zero-length run.
    n0 = n_done;
    issue_start(7, 0);
    for (int i = 0; i < 5; i++) begin
      chk("zero_busy",  32'(busy),      32'd0);
      chk("zero_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("zero_done", 32'(n_done - n0), 32'd1);

    // Start while busy is ignored; reset after three issues discards the run.
    r0 = n_rd;
    push_run(3, 10);
    issue_start(3, 10);
    issue_start(9, 2);
    k = 0;
    while ((n_rd - r0) < 3 && k < 50) begin
      tick();
      k++;
    end
    if ((n_rd - r0) < 3) chk("timeout_issue", 32'd1, 32'd0);
    rst_n = 1'b0;
    tick();
    chk_outputs_zero("midrst");
    q_addr.delete();
    q_data.delete();
    tick();
    rst_n = 1'b1;
    tick();
    p0 = n_pop;
    push_run(5, 2);
    issue_start(5, 2);
    wait_done(100, 1'b0);
    chk("post_rst_words", 32'(n_pop - p0), 32'd2);

`ifdef ROM_SEQ_ABORT_EN
    // Abort after three transfers, then a normal run.
    push_run(0, 8);
    issue_start(0, 8);
    p0 = n_pop;
    k = 0;
    while ((n_pop - p0) < 3 && k < 50) begin
      tick();
      k++;
    end
    if ((n_pop - p0) < 3) chk("timeout_xfer", 32'd1, 32'd0);
    n0 = n_done;
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q_addr.delete();
    q_data.delete();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    out_ready = 1'b1;
    p0 = n_pop;
    repeat (6) tick();
    chk("abort_no_words", 32'(n_pop - p0), 32'd0);
    chk("abort_no_done",  32'(n_done - n0), 32'd0);
    push_run(4, 3);
    issue_start(4, 3);
    wait_done(100, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
